fphub_add_special_pipe: RTL and testbench

- Parametrised, pipelined successor to the FPHUB adder special-case resolver.
- Classifies raw X and Y operands itself and supports both add and subtract.
- Emits the special result, a special/NaN flag pair and saturating event counters, behind a valid/ready handshake.
- Runs in parallel with the FPHUB adder datapath; downstream muxes `result` over the adder output when `is_special=1`.

---
 rtl/fphub_add_special_pipe.sv | 209 ++++++++++++++++++++
 tb/tb_fphub_add_special_pipe.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fphub_add_special_pipe.sv
// -----------------------------------------------------------------------------
// fphub_add_special_pipe
//
// Pipelined special-case resolver for the FPHUB adder. It runs alongside the
// adder datapath: it classifies both operands (after applying the subtract
// sign flip to Y), resolves infinities and zeros, and tells the downstream mux
// whether its result overrides the adder output. Saturating event counters
// track how many delivered results were special and how many were NaN.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   in_valid/ready  operand handshake (in_ready = out_ready | ~out_valid)
//   op_sub          0: X+Y, 1: X-Y
//   X, Y            operands {sign, exp[E], mant[M]}
//   out_valid/ready result handshake
//   result          special result, zero when is_special=0
//   is_special      result overrides the adder
//   is_nan          invalid operation (inf - inf)
//   cnt_clr         synchronous clear of both counters
//   special_count   delivered results with is_special=1 (saturating)
//   nan_count       delivered results with is_nan=1 (saturating)
// -----------------------------------------------------------------------------
module fphub_add_special_pipe #(
  parameter int M      = 23,
  parameter int E      = 8,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic [E+M:0]     X,
  input  logic [E+M:0]     Y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [E+M:0]     result,
  output logic             is_special,
  output logic             is_nan,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] special_count,
  output logic [CNT_W-1:0] nan_count
);

  localparam int W   = E + M + 1;
  localparam int L   = STAGES - 1;
  // Operand slots sit in front of the result slot; with one stage there are
  // none, but keep a dummy slot so the arrays stay legal.
  localparam int OPS = (STAGES > 1) ? STAGES - 1 : 1;

  localparam logic [2:0] CLS_NONE   = 3'd0;
  localparam logic [2:0] CLS_INF_P  = 3'd1;
  localparam logic [2:0] CLS_INF_N  = 3'd2;
  localparam logic [2:0] CLS_ZERO_P = 3'd3;
  localparam logic [2:0] CLS_ZERO_N = 3'd4;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [W-1:0]     POS_INF = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]     NEG_INF = {W{1'b1}};

  // Only the all-ones pattern counts as infinity; exp all ones with any other
  // mantissa is an ordinary value in this format.
  function automatic logic [2:0] classify(input logic [W-1:0] v);
    if (&v[W-2:0])
      return v[W-1] ? CLS_INF_N : CLS_INF_P;
    else if (~|v[W-2:0])
      return v[W-1] ? CLS_ZERO_N : CLS_ZERO_P;
    else
      return CLS_NONE;
  endfunction

  logic [STAGES-1:0]     valid_reg;
  logic [OPS-1:0][W-1:0] x_reg;
  logic [OPS-1:0][W-1:0] y_reg;
  logic [OPS-1:0][2:0]   xc_reg;
  logic [OPS-1:0][2:0]   yc_reg;
  logic [W-1:0]          res_reg;
  logic                  spec_reg;
  logic                  nan_reg;
  logic [CNT_W-1:0]      spec_cnt_reg;
  logic [CNT_W-1:0]      nan_cnt_reg;

  logic                  advance;
  logic                  out_hs;
  logic [W-1:0]          y_prime;
  logic [2:0]            xc_in;
  logic [2:0]            yc_in;

  // Resolution operands: taken from the last operand slot, or straight from
  // the input classification when the pipe is a single stage.
  logic                  r_valid;
  logic [W-1:0]          r_x;
  logic [W-1:0]          r_y;
  logic [2:0]            r_xc;
  logic [2:0]            r_yc;

  logic [W-1:0]          res_next;
  logic                  spec_next;
  logic                  nan_next;

  assign advance  = out_ready | ~valid_reg[L];
  assign in_ready = advance;
  assign out_hs   = valid_reg[L] & out_ready;

  assign y_prime = {Y[W-1] ^ op_sub, Y[W-2:0]};
  assign xc_in   = classify(X);
  assign yc_in   = classify(y_prime);

  generate
    if (STAGES > 1) begin : g_res_src_slot
      assign r_valid = valid_reg[L-1];
      assign r_x     = x_reg[OPS-1];
      assign r_y     = y_reg[OPS-1];
      assign r_xc    = xc_reg[OPS-1];
      assign r_yc    = yc_reg[OPS-1];
    end else begin : g_res_src_input
      assign r_valid = in_valid;
      assign r_x     = X;
      assign r_y     = y_prime;
      assign r_xc    = xc_in;
      assign r_yc    = yc_in;
    end
  endgenerate

  // Priority resolution. Bubbles resolve to an all-zero result so the output
  // registers never carry stale data.
  always_comb begin
    res_next  = '0;
    spec_next = 1'b0;
    nan_next  = 1'b0;
    if (r_valid) begin
      if ((r_xc == CLS_INF_P && r_yc == CLS_INF_N) ||
          (r_xc == CLS_INF_N && r_yc == CLS_INF_P)) begin
        res_next  = POS_INF;
        spec_next = 1'b1;
        nan_next  = 1'b1;
      end else if (r_xc == CLS_INF_P || r_yc == CLS_INF_P) begin
        res_next  = POS_INF;
        spec_next = 1'b1;
      end else if (r_xc == CLS_INF_N || r_yc == CLS_INF_N) begin
        res_next  = NEG_INF;
        spec_next = 1'b1;
      end else if (r_xc == CLS_ZERO_P && r_yc == CLS_ZERO_N) begin
        res_next  = '0;
        spec_next = 1'b1;
      end else if (r_xc == CLS_ZERO_P || r_xc == CLS_ZERO_N) begin
        res_next  = r_y;
        spec_next = 1'b1;
      end else if (r_yc == CLS_ZERO_P || r_yc == CLS_ZERO_N) begin
        res_next  = r_x;
        spec_next = 1'b1;
      end
    end
  end

  // Pipeline: every slot moves together whenever the output is free.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= '0;
      x_reg     <= '0;
      y_reg     <= '0;
      xc_reg    <= '0;
      yc_reg    <= '0;
      res_reg   <= '0;
      spec_reg  <= 1'b0;
      nan_reg   <= 1'b0;
    end else if (advance) begin
      valid_reg[0] <= in_valid;
      for (int i = 1; i < STAGES; i++) begin
        valid_reg[i] <= valid_reg[i-1];
      end
      x_reg[0]  <= X;
      y_reg[0]  <= y_prime;
      xc_reg[0] <= xc_in;
      yc_reg[0] <= yc_in;
      for (int i = 1; i < OPS; i++) begin
        x_reg[i]  <= x_reg[i-1];
        y_reg[i]  <= y_reg[i-1];
        xc_reg[i] <= xc_reg[i-1];
        yc_reg[i] <= yc_reg[i-1];
      end
      res_reg  <= res_next;
      spec_reg <= spec_next;
      nan_reg  <= nan_next;
    end
  end

  // Event counters; clear takes priority over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      spec_cnt_reg <= '0;
      nan_cnt_reg  <= '0;
    end else if (out_hs) begin
      if (spec_reg && spec_cnt_reg != CNT_MAX)
        spec_cnt_reg <= spec_cnt_reg + 1'b1;
      if (nan_reg && nan_cnt_reg != CNT_MAX)
        nan_cnt_reg <= nan_cnt_reg + 1'b1;
    end
  end

  assign out_valid     = valid_reg[L];
  assign result        = res_reg;
  assign is_special    = spec_reg;
  assign is_nan        = nan_reg;
  assign special_count = spec_cnt_reg;
  assign nan_count     = nan_cnt_reg;

endmodule

// File: tb/tb_fphub_add_special_pipe.sv
// -----------------------------------------------------------------------------
// tb_fphub_add_special_pipe
//
// Directed bench for fphub_add_special_pipe. Four instances share the input
// stimulus: the default configuration, single-stage, four-stage and a 2-bit
// counter variant. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_fphub_add_special_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        op_sub;
  logic [31:0] X;
  logic [31:0] Y;
  logic        out_ready;
  logic        cnt_clr;

  logic        in_ready,  out_valid,  is_special,  is_nan;
  logic [31:0] result;
  logic [15:0] special_count, nan_count;

  logic        s1_in_ready, s1_out_valid, s1_is_special, s1_is_nan;
  logic [31:0] s1_result;
  logic [15:0] s1_special_count, s1_nan_count;

  logic        s4_in_ready, s4_out_valid, s4_is_special, s4_is_nan;
  logic [31:0] s4_result;
  logic [15:0] s4_special_count, s4_nan_count;

  logic        st_in_ready, st_out_valid, st_is_special, st_is_nan;
  logic [31:0] st_result;
  logic [1:0]  st_special_count, st_nan_count;

  always #5 clk = ~clk;

  fphub_add_special_pipe u_main (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_sub(op_sub), .X(X), .Y(Y), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .is_special(is_special), .is_nan(is_nan), .cnt_clr(cnt_clr),
    .special_count(special_count), .nan_count(nan_count)
  );

  fphub_add_special_pipe #(.STAGES(1)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s1_in_ready),
    .op_sub(op_sub), .X(X), .Y(Y), .out_valid(s1_out_valid), .out_ready(out_ready),
    .result(s1_result), .is_special(s1_is_special), .is_nan(s1_is_nan), .cnt_clr(cnt_clr),
    .special_count(s1_special_count), .nan_count(s1_nan_count)
  );

  fphub_add_special_pipe #(.STAGES(4)) u_s4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s4_in_ready),
    .op_sub(op_sub), .X(X), .Y(Y), .out_valid(s4_out_valid), .out_ready(out_ready),
    .result(s4_result), .is_special(s4_is_special), .is_nan(s4_is_nan), .cnt_clr(cnt_clr),
    .special_count(s4_special_count), .nan_count(s4_nan_count)
  );

  fphub_add_special_pipe #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(st_in_ready),
    .op_sub(op_sub), .X(X), .Y(Y), .out_valid(st_out_valid), .out_ready(out_ready),
    .result(st_result), .is_special(st_is_special), .is_nan(st_is_nan), .cnt_clr(cnt_clr),
    .special_count(st_special_count), .nan_count(st_nan_count)
  );

  typedef struct {
    logic        op;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] res;
    logic        sp;
    logic        nan;
  } vec_t;

  localparam int NV = 14;
  vec_t vec [NV];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k);
    in_valid = 1'b1;
    op_sub   = vec[k].op;
    X        = vec[k].x;
    Y        = vec[k].y;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    op_sub   = 1'b0;
    X        = '0;
    Y        = '0;
  endtask

  int          lat1, lat2, lat4;
  int          out_cnt, in_idx;
  logic        stall, in_hs, found, seen;
  logic [31:0] held;

  initial begin
    vec[0]  = '{1'b0, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h7FFFFFFF, 1'b1, 1'b1};
    vec[1]  = '{1'b1, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h7FFFFFFF, 1'b1, 1'b0};
    vec[2]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0};
    vec[3]  = '{1'b0, 32'h00000000, 32'h80000000, 32'h00000000, 1'b1, 1'b0};
    vec[4]  = '{1'b0, 32'h80000000, 32'h80000000, 32'h80000000, 1'b1, 1'b0};
    vec[5]  = '{1'b0, 32'h80000000, 32'h00000000, 32'h00000000, 1'b1, 1'b0};
    vec[6]  = '{1'b1, 32'h00000000, 32'h40000000, 32'hC0000000, 1'b1, 1'b0};
    vec[7]  = '{1'b0, 32'h40000000, 32'h3F800000, 32'h00000000, 1'b0, 1'b0};
    vec[8]  = '{1'b0, 32'h7F800000, 32'h00000000, 32'h7F800000, 1'b1, 1'b0};
    vec[9]  = '{1'b0, 32'h3F800000, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0};
    vec[10] = '{1'b1, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 1'b0};
    vec[11] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h7FFFFFFF, 1'b1, 1'b1};
    vec[12] = '{1'b0, 32'h12345678, 32'h00000001, 32'h00000000, 1'b0, 1'b0};
    vec[13] = '{1'b0, 32'h80000000, 32'h12345678, 32'h12345678, 1'b1, 1'b0};

    rst = 1'b1; cnt_clr = 1'b0; out_ready = 1'b1;
    idle();
    step(); step();
    rst = 1'b0;
    step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_is_special", is_special, 0);
    chk("rst_is_nan", is_nan, 0);
    chk("rst_special_count", special_count, 0);
    chk("rst_nan_count", nan_count, 0);
    chk("rst_in_ready", in_ready, 1);

    // Latency of a single inf-inf operation across the three depths.
    lat1 = 0; lat2 = 0; lat4 = 0;
    drive(0);
    for (int n = 1; n <= 8; n++) begin
      step();
      idle();
      if (s1_out_valid && lat1 == 0) begin
        lat1 = n;
        chk("s1_result", s1_result, 32'h7FFFFFFF);
        chk("s1_is_nan", s1_is_nan, 1);
      end
      if (out_valid && lat2 == 0) lat2 = n;
      if (s4_out_valid && lat4 == 0) begin
        lat4 = n;
        chk("s4_result", s4_result, 32'h7FFFFFFF);
        chk("s4_is_nan", s4_is_nan, 1);
      end
    end
    chk("latency_s1", lat1, 1);
    chk("latency_s2", lat2, 2);
    chk("latency_s4", lat4, 4);
    chk("first_nan_count", nan_count, 1);
    chk("first_special_count", special_count, 1);
    $display("latency: s1=%0d s2=%0d s4=%0d", lat1, lat2, lat4);

    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    chk("clr_special_count", special_count, 0);

    // Table vectors, back-to-back at full throughput.
    for (int k = 0; k <= NV; k++) begin
      if (k < NV) drive(k); else idle();
      step();
      if (k >= 1) begin
        chk($sformatf("vec%0d_valid", k-1), out_valid, 1);
        chk($sformatf("vec%0d_result", k-1), result, vec[k-1].res);
        chk($sformatf("vec%0d_special", k-1), is_special, vec[k-1].sp);
        chk($sformatf("vec%0d_nan", k-1), is_nan, vec[k-1].nan);
        $display("vec %0d: op=%0d X=%h Y=%h -> result=%h sp=%0d nan=%0d",
                 k-1, vec[k-1].op, vec[k-1].x, vec[k-1].y, result, is_special, is_nan);
      end
    end
    idle();
    step();
    chk("table_special_count", special_count, 12);
    chk("table_nan_count", nan_count, 2);
    chk("table_drained", out_valid, 0);

    // Stream of 8 with a 3-cycle output stall.
    out_cnt = 0; in_idx = 0; held = '0;
    for (int cyc = 0; cyc < 40 && out_cnt < 8; cyc++) begin
      stall = (cyc >= 4 && cyc < 7);
      out_ready = ~stall;
      if (in_idx < 8) drive(in_idx); else idle();
      #1;
      if (stall) begin
        chk("stall_in_ready", in_ready, 0);
        chk("stall_out_valid", out_valid, 1);
        if (cyc == 4) held = result;
        else chk("stall_hold", result, held);
      end
      if (out_valid && out_ready) begin
        chk($sformatf("stream%0d_result", out_cnt), result, vec[out_cnt].res);
        chk($sformatf("stream%0d_special", out_cnt), is_special, vec[out_cnt].sp);
        $display("stream out %0d: result=%h sp=%0d", out_cnt, result, is_special);
        out_cnt++;
      end
      in_hs = in_valid & in_ready;
      step();
      if (in_hs) in_idx++;
    end
    out_ready = 1'b1;
    idle();
    chk("stream_out_count", out_cnt, 8);
    seen = 1'b0;
    for (int n = 0; n < 4; n++) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    chk("stream_no_dup", seen, 0);

    // Saturation of the 2-bit counter.
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(0);
      step();
    end
    idle();
    step(); step(); step();
    chk("sat_nan_count", st_nan_count, 3);
    chk("sat_special_count", st_special_count, 3);
    chk("wide_nan_count", nan_count, 5);
    $display("saturation: narrow nan=%0d wide nan=%0d", st_nan_count, nan_count);

    // Clear coinciding with a NaN output handshake.
    drive(0);
    step();
    idle();
    found = 1'b0;
    for (int n = 0; n < 10 && !found; n++) begin
      #1;
      if (out_valid) begin
        found = 1'b1;
        cnt_clr = 1'b1;
      end
      step();
      cnt_clr = 1'b0;
    end
    chk("clr_found", found, 1);
    chk("clr_wins_narrow", st_nan_count, 0);
    chk("clr_wins_wide", nan_count, 0);

    // Reset with two entries in flight.
    drive(0); step();
    drive(1); step();
    idle();
    rst = 1'b1;
    #1;
    chk("flush_pre_valid", out_valid, 1);
    step();
    rst = 1'b0;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_nan_count", nan_count, 0);
    chk("flush_special_count", special_count, 0);
    seen = 1'b0;
    for (int n = 0; n < 6; n++) begin
      step();
      if (out_valid || s4_out_valid || s1_out_valid) seen = 1'b1;
    end
    chk("flush_never_emitted", seen, 0);
    chk("flush_count_stays", special_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
